hamming1511_pipe: RTL and testbench

- Pipelined Hamming(15,11) single-error-correcting datapath: encode 11 data bits, optionally flip one codeword bit (fault injection), then decode and correct.
- Used as a streaming codec / self-test block for memory or link protection.
- One clock. No backpressure. One word accepted per cycle.

---
 rtl/hamming_pkg.sv | 54 +++++
 rtl/hamming_corrector.sv | 24 ++
 rtl/hamming1511_pipe.sv | 122 ++++++++++++
 tb/tb_hamming1511_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Hamming(15,11) constants and pure encode/syndrome/extract helpers.
// Codeword bit k carries Hamming position k+1; parity sits at positions 1,2,4,8.
package hamming_pkg;

  localparam int unsigned DATA_W  = 11;
  localparam int unsigned CODE_W  = 15;
  localparam int unsigned SYN_W   = 4;
  localparam int unsigned LATENCY = 3;

  // Hamming position of each data bit, data_in[0] first.
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Codeword bits whose position has syndrome bit j set (parity bit included).
  localparam logic [CODE_W-1:0] SYN_MASK0 = 15'h5555;
  localparam logic [CODE_W-1:0] SYN_MASK1 = 15'h6666;
  localparam logic [CODE_W-1:0] SYN_MASK2 = 15'h7878;
  localparam logic [CODE_W-1:0] SYN_MASK3 = 15'h7F80;

  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    s[0] = ^(code & SYN_MASK0);
    s[1] = ^(code & SYN_MASK1);
    s[2] = ^(code & SYN_MASK2);
    s[3] = ^(code & SYN_MASK3);
    return s;
  endfunction

  // Place data, then fill parity so the full word has zero syndrome.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    logic [SYN_W-1:0]  par;
    code = '0;
    for (int i = 0; i < DATA_W; i++) begin
      code[DATA_POS[i] - 4'd1] = data[i];
    end
    par     = syndrome(code);
    code[0] = par[0];
    code[1] = par[1];
    code[3] = par[2];
    code[7] = par[3];
    return code;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = code[DATA_POS[i] - 4'd1];
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_corrector.sv
// Combinational single-error corrector: syndrome, flip the named bit, extract data.
module hamming_corrector
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syndrome_c_o,
  output logic [DATA_W-1:0] data_c_o
);

  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] fixed;

  // Syndrome names the faulty position directly; zero means clean.
  always_comb begin
    syn   = syndrome(code_i);
    fixed = code_i;
    if (syn != '0) begin
      fixed[syn - 4'd1] = ~code_i[syn - 4'd1];
    end
    syndrome_c_o = syn;
    data_c_o     = extract(fixed);
  end

endmodule

// File: rtl/hamming1511_pipe.sv
// Three-stage Hamming(15,11) encode / fault-inject / correct pipeline.
// Optional HAMMING_ERR_FLAG_EN adds registered syndrome_out and err_corrected.
module hamming1511_pipe
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SYN_W-1:0]  err_pos,
  input  logic              err_inject,
  output logic              out_valid,
  output logic [CODE_W-1:0] code_out,
  output logic [CODE_W-1:0] corrupted_out,
  output logic [DATA_W-1:0] data_out
`ifdef HAMMING_ERR_FLAG_EN
  ,
  output logic [SYN_W-1:0]  syndrome_out,
  output logic              err_corrected
`endif
);

  logic              v1_q;
  logic [CODE_W-1:0] enc_q;
  logic [SYN_W-1:0]  err_pos_q;
  logic              err_inject_q;

  logic              v2_q;
  logic [CODE_W-1:0] clean_q;
  logic [CODE_W-1:0] corr_q;
  logic [CODE_W-1:0] corr_d;

  logic              v3_q;
  logic [CODE_W-1:0] code_out_q;
  logic [CODE_W-1:0] corr_out_q;
  logic [DATA_W-1:0] data_out_q;

  logic [SYN_W-1:0]  syn_c;
  logic [DATA_W-1:0] fix_data_c;

  // S1: encode incoming data and hold the injection request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      enc_q        <= '0;
      err_pos_q    <= '0;
      err_inject_q <= 1'b0;
    end else begin
      v1_q         <= in_valid;
      enc_q        <= encode(data_in);
      err_pos_q    <= err_pos;
      err_inject_q <= err_inject;
    end
  end

  // Injector: flip exactly one position when requested and nonzero.
  always_comb begin
    corr_d = enc_q;
    if (err_inject_q && (err_pos_q != '0)) begin
      corr_d[err_pos_q - 4'd1] = ~enc_q[err_pos_q - 4'd1];
    end
  end

  // S2: clean and corrupted words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      clean_q <= '0;
      corr_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      clean_q <= enc_q;
      corr_q  <= corr_d;
    end
  end

  hamming_corrector u_corrector (
    .code_i       (corr_q),
    .syndrome_c_o (syn_c),
    .data_c_o     (fix_data_c)
  );

  // S3: output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_q       <= 1'b0;
      code_out_q <= '0;
      corr_out_q <= '0;
      data_out_q <= '0;
    end else begin
      v3_q       <= v2_q;
      code_out_q <= clean_q;
      corr_out_q <= corr_q;
      data_out_q <= fix_data_c;
    end
  end

  assign out_valid     = v3_q;
  assign code_out      = code_out_q;
  assign corrupted_out = corr_out_q;
  assign data_out      = data_out_q;

`ifdef HAMMING_ERR_FLAG_EN
  logic [SYN_W-1:0] syn_out_q;
  logic             err_corr_q;

  // S3 error flags, aligned with the data outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syn_out_q  <= '0;
      err_corr_q <= 1'b0;
    end else begin
      syn_out_q  <= syn_c;
      err_corr_q <= (syn_c != '0);
    end
  end

  assign syndrome_out  = syn_out_q;
  assign err_corrected = err_corr_q;
`endif

endmodule

// File: tb/tb_hamming1511_pipe.sv
// Directed bench for hamming1511_pipe; set HAMMING_ERR_FLAG_EN to also check the flags.
module tb_hamming1511_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] data_in;
  logic [3:0]  err_pos;
  logic        err_inject;
  logic        out_valid;
  logic [14:0] code_out;
  logic [14:0] corrupted_out;
  logic [10:0] data_out;
`ifdef HAMMING_ERR_FLAG_EN
  logic [3:0]  syndrome_out;
  logic        err_corrected;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  hamming1511_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .data_in       (data_in),
    .err_pos       (err_pos),
    .err_inject    (err_inject),
    .out_valid     (out_valid),
    .code_out      (code_out),
    .corrupted_out (corrupted_out),
    .data_out      (data_out)
`ifdef HAMMING_ERR_FLAG_EN
    ,
    .syndrome_out  (syndrome_out),
    .err_corrected (err_corrected)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] d, input logic [3:0] p,
                       input logic inj);
    in_valid   = v;
    data_in    = d;
    err_pos    = p;
    err_inject = inj;
  endtask

  task automatic chk_word(input string tag, input logic [14:0] c, input logic [14:0] cc,
                          input logic [10:0] d, input logic [3:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".code"},  32'(code_out), 32'(c));
    chk({tag, ".corr"},  32'(corrupted_out), 32'(cc));
    chk({tag, ".data"},  32'(data_out), 32'(d));
`ifdef HAMMING_ERR_FLAG_EN
    chk({tag, ".syn"},   32'(syndrome_out), 32'(s));
    chk({tag, ".flag"},  32'(err_corrected), 32'(s != 4'd0));
`else
    if (s > 4'd15) chk({tag, ".syn"}, 32'(s), 32'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".code"},  32'(code_out), 32'd0);
    chk({tag, ".corr"},  32'(corrupted_out), 32'd0);
    chk({tag, ".data"},  32'(data_out), 32'd0);
`ifdef HAMMING_ERR_FLAG_EN
    chk({tag, ".syn"},   32'(syndrome_out), 32'd0);
    chk({tag, ".flag"},  32'(err_corrected), 32'd0);
`endif
  endtask

  // Single word: out_valid must stay low for two edges and rise on the third.
  task automatic run_one(input string tag, input logic [10:0] d, input logic [3:0] p,
                         input logic inj, input logic [14:0] ec, input logic [14:0] ecc,
                         input logic [10:0] ed, input logic [3:0] es);
    @(negedge clk);
    drive(1'b1, d, p, inj);
    @(negedge clk);
    drive(1'b0, 11'h000, 4'd0, 1'b0);
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_word(tag, ec, ecc, ed, es);
    @(negedge clk);
    chk({tag, ".drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 11'h000, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run_one("clean001",  11'h001, 4'd0,  1'b0, 15'h0007, 15'h0007, 11'h001, 4'd0);
    run_one("inj5",      11'h001, 4'd5,  1'b1, 15'h0007, 15'h0017, 11'h001, 4'd5);
    run_one("inj8_ones", 11'h7FF, 4'd8,  1'b1, 15'h7FFF, 15'h7F7F, 11'h7FF, 4'd8);
    run_one("inj1_par",  11'h001, 4'd1,  1'b1, 15'h0007, 15'h0006, 11'h001, 4'd1);
    run_one("pos0",      11'h000, 4'd0,  1'b1, 15'h0000, 15'h0000, 11'h000, 4'd0);
    run_one("noinj3",    11'h000, 4'd3,  1'b0, 15'h0000, 15'h0000, 11'h000, 4'd0);
    run_one("inj15",     11'h400, 4'd15, 1'b1, 15'h408B, 15'h008B, 11'h400, 4'd15);

    // Back-to-back stream, then reset with two words still in flight.
    @(negedge clk); drive(1'b1, 11'h001, 4'd0,  1'b0);
    @(negedge clk); drive(1'b1, 11'h7FF, 4'd8,  1'b1);
    @(negedge clk); drive(1'b1, 11'h400, 4'd15, 1'b1);
    @(negedge clk); drive(1'b1, 11'h001, 4'd5,  1'b1);
    chk_word("s0", 15'h0007, 15'h0007, 11'h001, 4'd0);
    @(negedge clk); drive(1'b1, 11'h001, 4'd1,  1'b1);
    chk_word("s1", 15'h7FFF, 15'h7F7F, 11'h7FF, 4'd8);
    @(negedge clk); drive(1'b1, 11'h7FF, 4'd3,  1'b1);
    chk_word("s2", 15'h408B, 15'h008B, 11'h400, 4'd15);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 11'h000, 4'd0, 1'b0);
    chk_zero("mid_rst");
    @(negedge clk);
    chk_zero("flush1");
    @(negedge clk);
    chk_zero("flush2");

    run_one("post_rst",  11'h001, 4'd5,  1'b1, 15'h0007, 15'h0017, 11'h001, 4'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
